// File: rtl/hzz_master_arb.sv
// Round-robin HZZ master: grants one requester at a time, issues its command, streams write data or returns read data.
// Command on the bus the cycle after req_valid is sampled in IDLE; requesters are held until granted.
module hzz_master_arb #(
    parameter int HZZ_T2D_WIDTH = 64,
    parameter int NUM_REQ       = 4,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    input  logic [NUM_REQ-1:0]               req_wr,
    input  logic [NUM_REQ*54-1:0]            req_addr,
    input  logic [NUM_REQ*8-1:0]             req_len,
    output logic [NUM_REQ-1:0]               req_gnt,
    output logic [NUM_REQ-1:0]               req_wpop,
    input  logic [NUM_REQ*HZZ_T2D_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]               req_rvalid,
    output logic [HZZ_T2D_WIDTH-1:0]         req_rdata,
    output logic [NUM_REQ-1:0]               req_done,
    output logic                             req_err,
    input  logic                             err_clr,
    output logic                             err_sticky,
    output logic                             busy,
    output logic [HZZ_T2D_WIDTH-1:0]         hzzm_mosi,
    output logic                             hzzm_mosi_valid,
    output logic                             hzzm_mosi_en,
    input  logic [HZZ_T2D_WIDTH-1:0]         hzzm_miso,
    input  logic                             hzzm_miso_valid,
    output logic                             hzzm_miso_en
);
    localparam int W  = HZZ_T2D_WIDTH;
    localparam int OW = $clog2(NUM_REQ);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_WRESP, S_RDATA, S_DONE} state_t;

    state_t               r_state, w_state_nxt;
    logic [OW-1:0]        r_ptr, w_ptr_nxt, r_owner, w_owner_nxt, w_pick;
    logic                 r_wr, w_wr_nxt, r_fail, w_fail_nxt, w_found, w_legal, w_set_err;
    logic [7:0]           r_len, w_len_nxt, r_cnt, w_cnt_nxt;
    logic [TW-1:0]        r_to, w_to_nxt;
    logic [53:0]          w_sel_addr;
    logic [7:0]           w_sel_len;
    logic                 w_sel_wr;
    logic [W-1:0]         w_cmd, w_mosi_nxt;
    logic [NUM_REQ-1:0]   w_owner_oh, w_nxt_oh;
    logic [NUM_REQ-1:0]   r_gnt, r_done;
    logic                 r_err, r_sticky, r_busy, r_mosi_vld, r_mosi_en, r_miso_en;
    logic [W-1:0]         r_mosi;

    // Round-robin search starting at r_ptr.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_pick  = OW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    assign w_sel_addr = req_addr[54*int'(w_pick) +: 54];
    assign w_sel_len  = req_len[8*int'(w_pick) +: 8];
    assign w_sel_wr   = req_wr[w_pick];
    assign w_legal    = (w_sel_addr[1:0] == 2'b00) && (w_sel_len[1:0] == 2'b11);

    always_comb begin
        w_cmd          = '0;
        w_cmd[W-1]     = w_sel_wr;
        w_cmd[W-2]     = ~w_sel_wr;
        w_cmd[W-3 -: 8] = w_sel_len;
        w_cmd[53:0]    = w_sel_addr;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_owner_nxt = r_owner;
        w_wr_nxt    = r_wr;
        w_len_nxt   = r_len;
        w_cnt_nxt   = r_cnt;
        w_to_nxt    = r_to;
        w_fail_nxt  = r_fail;
        w_set_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_owner_nxt = w_pick;
                    w_wr_nxt    = w_sel_wr;
                    w_len_nxt   = w_sel_len;
                    if (w_legal) begin
                        w_state_nxt = S_CMD;
                        w_fail_nxt  = 1'b0;
                        w_ptr_nxt   = (w_pick == OW'(NUM_REQ - 1)) ? '0 : w_pick + OW'(1);
                    end else begin
                        w_state_nxt = S_DONE;
                        w_fail_nxt  = 1'b1;
                        w_set_err   = 1'b1;
                    end
                end
            end
            S_CMD: begin
                w_cnt_nxt   = r_len;
                w_to_nxt    = '0;
                w_state_nxt = r_wr ? S_WDATA : S_RDATA;
            end
            S_WDATA: begin
                if (r_cnt == 8'd0) w_state_nxt = S_WRESP;
                else               w_cnt_nxt   = r_cnt - 8'd1;
            end
            S_WRESP, S_RDATA: begin
                if (hzzm_miso_valid) begin
                    w_to_nxt = '0;
                    if (r_state == S_WRESP || r_cnt == 8'd0) w_state_nxt = S_DONE;
                    else                                       w_cnt_nxt   = r_cnt - 8'd1;
                end else if (r_to == TW'(TIMEOUT_CYC - 1)) begin
                    w_state_nxt = S_DONE;
                    w_fail_nxt  = 1'b1;
                    w_set_err   = 1'b1;
                end else begin
                    w_to_nxt = r_to + TW'(1);
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // A slave word outside the response/read window is dropped but flagged.
        if (hzzm_miso_valid && r_state != S_WRESP && r_state != S_RDATA) w_set_err = 1'b1;
    end

    assign w_owner_oh = NUM_REQ'(1) << r_owner;
    assign w_nxt_oh   = NUM_REQ'(1) << w_owner_nxt;

    always_comb begin
        w_mosi_nxt = '0;
        if (w_state_nxt == S_CMD)        w_mosi_nxt = w_cmd;
        else if (w_state_nxt == S_WDATA) w_mosi_nxt = req_wdata[W*int'(r_owner) +: W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_wr       <= 1'b0;
            r_len      <= '0;
            r_cnt      <= '0;
            r_to       <= '0;
            r_fail     <= 1'b0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_sticky   <= 1'b0;
            r_busy     <= 1'b0;
            r_mosi     <= '0;
            r_mosi_vld <= 1'b0;
            r_mosi_en  <= 1'b1;
            r_miso_en  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_owner    <= w_owner_nxt;
            r_wr       <= w_wr_nxt;
            r_len      <= w_len_nxt;
            r_cnt      <= w_cnt_nxt;
            r_to       <= w_to_nxt;
            r_fail     <= w_fail_nxt;
            // A rejected request is granted and retired together in DONE.
            r_gnt      <= (w_state_nxt == S_CMD || (w_state_nxt == S_DONE && r_state == S_IDLE)) ? w_nxt_oh : '0;
            r_done     <= (w_state_nxt == S_DONE) ? w_nxt_oh : '0;
            r_err      <= (w_state_nxt == S_DONE) && w_fail_nxt;
            r_busy     <= (w_state_nxt != S_IDLE);
            r_mosi     <= w_mosi_nxt;
            r_mosi_vld <= (w_state_nxt == S_CMD) || (w_state_nxt == S_WDATA);
            r_mosi_en  <= (w_state_nxt != S_RDATA);
            r_miso_en  <= (w_state_nxt == S_WRESP) || (w_state_nxt == S_RDATA);
            if (w_set_err)    r_sticky <= 1'b1;
            else if (err_clr) r_sticky <= 1'b0;
        end
    end

    // Pops run from CMD through the second-to-last WDATA cycle: len+1 in total.
    assign req_wpop        = (((r_state == S_CMD) && r_wr) || ((r_state == S_WDATA) && (r_cnt != 8'd0))) ? w_owner_oh : '0;
    assign req_rvalid      = ((r_state == S_RDATA) && hzzm_miso_valid) ? w_owner_oh : '0;
    assign req_rdata       = hzzm_miso;
    assign req_gnt         = r_gnt;
    assign req_done        = r_done;
    assign req_err         = r_err;
    assign err_sticky      = r_sticky;
    assign busy            = r_busy;
    assign hzzm_mosi       = r_mosi;
    assign hzzm_mosi_valid = r_mosi_vld;
    assign hzzm_mosi_en    = r_mosi_en;
    assign hzzm_miso_en    = r_miso_en;
endmodule

// File: tb/tb_hzz_master_arb.sv
// Directed bench for hzz_master_arb with a scoreboard for bus words and returned read beats.
module tb_hzz_master_arb;
    localparam int W  = 64;
    localparam int N  = 4;
    localparam int TO = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_wr, req_gnt, req_wpop, req_rvalid, req_done;
    logic [N*54-1:0]  req_addr;
    logic [N*8-1:0]   req_len;
    logic [N*W-1:0]   req_wdata;
    logic [W-1:0]     req_rdata, hzzm_mosi, hzzm_miso;
    logic             req_err, err_clr, err_sticky, busy;
    logic             hzzm_mosi_valid, hzzm_mosi_en, hzzm_miso_valid, hzzm_miso_en;

    always #5 clk = ~clk;

    hzz_master_arb #(.HZZ_T2D_WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_len(req_len),
        .req_gnt(req_gnt), .req_wpop(req_wpop), .req_wdata(req_wdata),
        .req_rvalid(req_rvalid), .req_rdata(req_rdata), .req_done(req_done), .req_err(req_err),
        .err_clr(err_clr), .err_sticky(err_sticky), .busy(busy),
        .hzzm_mosi(hzzm_mosi), .hzzm_mosi_valid(hzzm_mosi_valid), .hzzm_mosi_en(hzzm_mosi_en),
        .hzzm_miso(hzzm_miso), .hzzm_miso_valid(hzzm_miso_valid), .hzzm_miso_en(hzzm_miso_en)
    );

    typedef struct { int owner; logic [W-1:0] dat; } rd_t;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] mosi_q[$];
    rd_t          rd_q[$];
    int           wptr[N];
    int           pops[N];
    int           last_wait;

    function automatic logic [W-1:0] wpat(int i, int b);
        return {8'(i), 24'hC0FFEE, 32'(b)};
    endfunction

    function automatic logic [W-1:0] cmdw(bit wr, logic [53:0] a, logic [7:0] l);
        logic [W-1:0] c;
        c = '0;
        c[W-1] = wr;
        c[W-2] = ~wr;
        c[W-3 -: 8] = l;
        c[53:0] = a;
        return c;
    endfunction

    function automatic logic [N-1:0] oh(int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(string tag, logic [W-1:0] obs, logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Combinational outputs are sampled at the falling edge, registered ones just after the rising edge.
    task automatic tick();
        logic [N-1:0] pop;
        rd_t          e;
        @(negedge clk);
        pop = req_wpop;
        if (req_rvalid != '0) begin
            if (rd_q.size() == 0) chk("rvalid_unexpected", W'(req_rvalid), '0);
            else begin
                e = rd_q.pop_front();
                chk("rvalid_owner", W'(req_rvalid), W'(oh(e.owner)));
                chk("rdata", req_rdata, e.dat);
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (pop[i]) begin
                wptr[i]++;
                pops[i]++;
            end
            req_wdata[W*i +: W] = wpat(i, wptr[i]);
        end
        if (hzzm_mosi_valid) begin
            if (mosi_q.size() == 0) chk("mosi_unexpected", W'(hzzm_mosi_valid), '0);
            else                    chk("mosi_word", hzzm_mosi, mosi_q.pop_front());
        end
    endtask

    task automatic set_req(int i, bit wr, logic [53:0] a, logic [7:0] l);
        req_wr[i]          = wr;
        req_addr[54*i +: 54] = a;
        req_len[8*i +: 8]  = l;
        req_valid[i]       = 1'b1;
    endtask

    task automatic wait_gnt(int own, bit keep);
        int t;
        t = 0;
        while (req_gnt == '0 && t < 8) begin
            tick();
            t++;
        end
        last_wait = t;
        chk("gnt", W'(req_gnt), W'(oh(own)));
        if (!keep) req_valid[own] = 1'b0;
    endtask

    task automatic read_burst(int own, logic [53:0] a, logic [7:0] l, int beats, bit keep);
        logic [W-1:0] d;
        rd_t          r;
        mosi_q.push_back(cmdw(1'b0, a, l));
        wait_gnt(own, keep);
        tick();
        chk("rd_miso_en", W'(hzzm_miso_en), W'(1));
        chk("rd_mosi_en", W'(hzzm_mosi_en), W'(0));
        for (int b = 0; b < beats; b++) begin
            d = {$urandom, $urandom};
            hzzm_miso = d;
            hzzm_miso_valid = 1'b1;
            r.owner = own;
            r.dat = d;
            rd_q.push_back(r);
            tick();
        end
        hzzm_miso_valid = 1'b0;
        hzzm_miso = '0;
        if (beats == int'(l) + 1) begin
            chk("rd_done", W'(req_done), W'(oh(own)));
            chk("rd_err", W'(req_err), W'(0));
            chk("rd_beats_left", W'(rd_q.size()), W'(0));
        end
    endtask

    task automatic chk_reset_vals(string tag);
        chk({tag, "_mosi"}, hzzm_mosi, '0);
        chk({tag, "_mosi_valid"}, W'(hzzm_mosi_valid), W'(0));
        chk({tag, "_mosi_en"}, W'(hzzm_mosi_en), W'(1));
        chk({tag, "_miso_en"}, W'(hzzm_miso_en), W'(0));
        chk({tag, "_gnt_done"}, W'({req_gnt, req_done, req_wpop, req_rvalid}), W'(0));
        chk({tag, "_err_sticky_busy"}, W'({req_err, err_sticky, busy}), W'(0));
    endtask

    initial begin
        int mv, t;
        rst = 1'b1;
        req_valid = '0; req_wr = '0; req_addr = '0; req_len = '0; req_wdata = '0;
        err_clr = 1'b0; hzzm_miso = '0; hzzm_miso_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            wptr[i] = 0;
            pops[i] = 0;
        end
        tick();
        tick();
        chk_reset_vals("reset");
        rst = 1'b0;
        tick();

        // Four contending readers: round-robin 0,1,2,3 then 0 again, one IDLE between bursts.
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 54'h400 + 54'(16 * i), 8'd3);
        read_burst(0, 54'h400, 8'd3, 4, 1'b1);
        chk("arb_latency", W'(last_wait), W'(1));
        for (int i = 1; i <= N; i++) begin
            read_burst(i % N, 54'h400 + 54'(16 * (i % N)), 8'd3, 4, 1'b0);
            chk("arb_gap", W'(last_wait), W'(2));
        end

        // Single read from requester 1.
        set_req(1, 1'b0, 54'h100, 8'd3);
        read_burst(1, 54'h100, 8'd3, 4, 1'b0);

        // Single write from requester 0, len 7.
        set_req(0, 1'b1, 54'h200, 8'd7);
        mosi_q.push_back(cmdw(1'b1, 54'h200, 8'd7));
        for (int k = 0; k < 8; k++) mosi_q.push_back(wpat(0, wptr[0] + k));
        pops[0] = 0;
        wait_gnt(0, 1'b0);
        mv = int'(hzzm_mosi_valid);
        for (int k = 0; k < 8; k++) begin
            tick();
            if (hzzm_mosi_valid) mv++;
        end
        chk("wr_mosi_valid_cycles", W'(mv), W'(9));
        tick();
        chk("wr_resp_wait_idle_bus", W'(hzzm_mosi_valid), W'(0));
        chk("wr_resp_miso_en", W'(hzzm_miso_en), W'(1));
        chk("wr_pops", W'(pops[0]), W'(8));
        hzzm_miso_valid = 1'b1;
        tick();
        hzzm_miso_valid = 1'b0;
        chk("wr_done", W'(req_done), W'(oh(0)));
        chk("wr_err", W'(req_err), W'(0));
        chk("wr_words_left", W'(mosi_q.size()), W'(0));
        tick();

        // Illegal requests: misaligned address, then bad length.
        set_req(2, 1'b0, 54'h101, 8'd3);
        tick();
        req_valid[2] = 1'b0;
        chk("ill_addr_gnt", W'(req_gnt), W'(oh(2)));
        chk("ill_addr_done", W'(req_done), W'(oh(2)));
        chk("ill_addr_err", W'(req_err), W'(1));
        chk("ill_addr_sticky", W'(err_sticky), W'(1));
        tick();
        chk("ill_sticky_holds", W'(err_sticky), W'(1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("ill_sticky_clr", W'(err_sticky), W'(0));
        set_req(3, 1'b1, 54'h300, 8'd4);
        tick();
        req_valid[3] = 1'b0;
        chk("ill_len_gnt_done", W'({req_gnt, req_done}), W'({oh(3), oh(3)}));
        chk("ill_len_err", W'(req_err), W'(1));
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // Stray slave word in IDLE; set wins over a simultaneous clear.
        hzzm_miso_valid = 1'b1;
        tick();
        hzzm_miso_valid = 1'b0;
        chk("stray_sticky", W'(err_sticky), W'(1));
        hzzm_miso_valid = 1'b1;
        err_clr = 1'b1;
        tick();
        hzzm_miso_valid = 1'b0;
        chk("set_beats_clr", W'(err_sticky), W'(1));
        tick();
        err_clr = 1'b0;
        chk("clr_after_set", W'(err_sticky), W'(0));

        // Read cut short by a silent slave.
        set_req(1, 1'b0, 54'h500, 8'd3);
        read_burst(1, 54'h500, 8'd3, 2, 1'b0);
        t = 0;
        while (req_done == '0 && t < 200) begin
            tick();
            t++;
        end
        chk("to_cycles", W'(t), W'(TO));
        chk("to_done", W'(req_done), W'(oh(1)));
        chk("to_err", W'(req_err), W'(1));
        chk("to_sticky", W'(err_sticky), W'(1));
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        set_req(3, 1'b0, 54'h600, 8'd3);
        read_burst(3, 54'h600, 8'd3, 4, 1'b0);

        // Reset in the middle of a write from requester 2 (pointer would otherwise favour 3).
        set_req(2, 1'b1, 54'h700, 8'd7);
        mosi_q.push_back(cmdw(1'b1, 54'h700, 8'd7));
        for (int k = 0; k < 8; k++) mosi_q.push_back(wpat(2, wptr[2] + k));
        wait_gnt(2, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        mosi_q.delete();
        chk_reset_vals("midrst");
        tick();
        rst = 1'b0;
        set_req(2, 1'b0, 54'h800, 8'd3);
        set_req(3, 1'b0, 54'h810, 8'd3);
        read_burst(2, 54'h800, 8'd3, 4, 1'b0);
        read_burst(3, 54'h810, 8'd3, 4, 1'b0);

        // Longest burst: 256 beats.
        set_req(1, 1'b0, 54'h900, 8'hFF);
        read_burst(1, 54'h900, 8'hFF, 256, 1'b0);

        tick();
        chk("final_busy", W'(busy), W'(0));
        chk("final_queues", W'(mosi_q.size() + rd_q.size()), W'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
